// File: rtl/fifo8x16.sv
// fifo8x16: 8-entry x 16-bit synchronous FIFO with valid/ready handshakes on both sides.
// Storage is eight 16-bit registers written through a one-hot decode of wr_ptr. The head
// word is selected by mux8way16 using rd_ptr (show-ahead, no bypass).
// Optional build macro FIFO8_ERR_FLAGS_EN adds sticky overflow/underflow outputs.

module mux8way16 (
  input  logic [15:0] d0,
  input  logic [15:0] d1,
  input  logic [15:0] d2,
  input  logic [15:0] d3,
  input  logic [15:0] d4,
  input  logic [15:0] d5,
  input  logic [15:0] d6,
  input  logic [15:0] d7,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  // 8-way word select
  always_comb begin
    out = d0;
    case (sel)
      3'd1:    out = d1;
      3'd2:    out = d2;
      3'd3:    out = d3;
      3'd4:    out = d4;
      3'd5:    out = d5;
      3'd6:    out = d6;
      3'd7:    out = d7;
      default: out = d0;
    endcase
  end

endmodule

module fifo8x16 #(
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  count,
  output logic        almost_full,
  output logic        almost_empty
`ifdef FIFO8_ERR_FLAGS_EN
  ,
  output logic        overflow,
  output logic        underflow
`endif
);

  localparam logic [3:0] AFULL_CNT  = AFULL_LEVEL[3:0];
  localparam logic [3:0] AEMPTY_CNT = AEMPTY_LEVEL[3:0];

  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [15:0] storage [8];
  logic [7:0]  wr_sel;
  logic        push;
  logic        pop;

  // Handshake status comes only from registered occupancy; flush suppresses any transfer
  assign in_ready     = (count != 4'd8);
  assign out_valid    = (count != 4'd0);
  assign push         = in_valid && in_ready && !flush;
  assign pop          = out_valid && out_ready && !flush;
  assign wr_sel       = 8'd1 << wr_ptr;
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else if (flush) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_storage
    // Storage word i, loaded when the one-hot write select picks it
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        storage[i] <= 16'h0000;
      else if (push && wr_sel[i])
        storage[i] <= in_data;
    end
  end

  mux8way16 u_head_mux (
    .d0  (storage[0]),
    .d1  (storage[1]),
    .d2  (storage[2]),
    .d3  (storage[3]),
    .d4  (storage[4]),
    .d5  (storage[5]),
    .d6  (storage[6]),
    .d7  (storage[7]),
    .sel (rd_ptr),
    .out (out_data)
  );

`ifdef FIFO8_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready)   overflow  <= 1'b1;
      if (out_ready && !out_valid) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo8x16.sv
// Directed self-checking bench for fifo8x16.
// Inputs change and outputs are checked 1 time unit after each rising clk edge.

module tb_fifo8x16;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  count;
  logic        almost_full;
  logic        almost_empty;
`ifdef FIFO8_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo8x16 dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO8_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_words [3];
    exp_words[0] = 16'h1111;
    exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = exp_words[i];
      tick();
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL basic_push_count got %0d exp %0d", count, i + 1); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid_latency got %b exp 1", out_valid); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data !== exp_words[i]) begin errors++; $display("FAIL basic_pop_data got %h exp %h", out_data, exp_words[i]); end
      tick();
      checks++; if (count !== 4'(2 - i)) begin errors++; $display("FAIL basic_pop_count got %0d exp %0d", count, 2 - i); end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hA000 + 16'(i);
      tick();
      checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL full_almost_full got %b at count %0d", almost_full, i + 1); end
      checks++; if (almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL full_almost_empty got %b at count %0d", almost_empty, i + 1); end
    end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refused_count got %0d exp 8", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_data !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL full_pop_data got %h exp %h", out_data, 16'hA000 + 16'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_full_simul();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'hB000 + 16'(i);
      tick();
    end
    in_data   = 16'hC0DE;
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL simul_full_count got %0d exp 7", count); end
    checks++; if (out_data !== 16'hB001) begin errors++; $display("FAIL simul_full_head got %h exp b001", out_data); end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL simul_refill_count got %0d exp 8", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b0;
    checks++; if (out_data !== 16'hC0DE) begin errors++; $display("FAIL simul_last_data got %h exp c0de", out_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h0100 + 16'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain_count got %0d exp 0", count); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL wrap_stale_data got %h exp 0000", out_data); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty_pop_count got %0d exp 0", count); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5A5A;
    tick();
    checks++; if (out_data !== 16'h5A5A) begin errors++; $display("FAIL wrap_head got %h exp 5a5a", out_data); end
    in_data   = 16'h6B6B;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_simul_count got %0d exp 1", count); end
    checks++; if (out_data !== 16'h6B6B) begin errors++; $display("FAIL wrap_simul_head got %h exp 6b6b", out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'hD000 + 16'(i);
      tick();
    end
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL areset_pre_count got %0d exp 4", count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL areset_out_data got %h exp 0000", out_data); end
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'hE000 + 16'(i);
      tick();
    end
    flush     = 1'b1;
    in_data   = 16'hFFFF;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'hE000) begin errors++; $display("FAIL flush_storage_kept got %h exp e000", out_data); end
  endtask

`ifdef FIFO8_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_overflow_reset got %b exp 0", overflow); end
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_overflow_set got %b exp 1", overflow); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_overflow_flush got %b exp 0", overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_underflow_set got %b exp 1", underflow); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_full_simul();
    test_wrap();
    test_async_reset();
    test_flush();
`ifdef FIFO8_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
